enemy_shell_ctl: RTL and testbench



---
 rtl/enemy_shell_ctl_pkg.sv | 26 ++
 rtl/enemy_shell_ctl_frame_tick_gen.sv | 20 ++
 rtl/enemy_shell_ctl.sv | 150 +++++++++++++++
 tb/tb_enemy_shell_ctl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/enemy_shell_ctl_pkg.sv
// Shared codes for the enemy shell path:
// direction codes, FSM states, screen limits.
package enemy_shell_ctl_pkg;

  localparam logic [2:0] DIR_NONE  = 3'd0;
  localparam logic [2:0] DIR_UP    = 3'd1;
  localparam logic [2:0] DIR_DOWN  = 3'd2;
  localparam logic [2:0] DIR_RIGHT = 3'd3;
  localparam logic [2:0] DIR_LEFT  = 3'd4;

  localparam int X_MAX = 799;
  localparam int Y_MAX = 599;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLIGHT   = 2'd1,
    ST_COOLDOWN = 2'd2
  } shell_state_t;

  function automatic logic dir_valid(
    input logic [2:0] d
  );
    return (d >= DIR_UP) && (d <= DIR_LEFT);
  endfunction

endpackage

// File: rtl/enemy_shell_ctl_frame_tick_gen.sv
// Rising-edge detector on vblnk: one-cycle
// frame tick, shared with the player shell path.
module frame_tick_gen (
  input  logic clk,
  input  logic rst,
  input  logic vblnk,
  output logic tick
);

  logic vblnk_q;

  // delay vblnk by one cycle for edge detect
  always_ff @(posedge clk) begin
    if (rst) vblnk_q <= 1'b0;
    else     vblnk_q <= vblnk;
  end

  assign tick = vblnk & ~vblnk_q;

endmodule

// File: rtl/enemy_shell_ctl.sv
// Enemy shell flight sequencer: launch,
// per-frame move, termination, reload cooldown.
module enemy_shell_ctl
  import enemy_shell_ctl_pkg::*;
#(
  parameter int SPEED    = 4,
  parameter int X_MAX_P  = X_MAX,
  parameter int Y_MAX_P  = Y_MAX,
  parameter int COOLDOWN = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vblnk,
  input  logic       fire,
  input  logic [2:0] fire_dir,
  input  logic [9:0] tank_x,
  input  logic [9:0] tank_y,
  input  logic       hit_tank,
  input  logic       hit_obstacle,
  output logic [9:0] xpos_bullet,
  output logic [9:0] ypos_bullet,
  output logic [2:0] direction,
  output logic       ready,
  output logic [7:0] shots_fired
);

  localparam int CW =
    (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN);
  localparam logic [10:0] SPD11 = 11'(SPEED);
  localparam logic [9:0]  SPD10 = 10'(SPEED);
  localparam logic [10:0] XLIM  = 11'(X_MAX_P);
  localparam logic [10:0] YLIM  = 11'(Y_MAX_P);

  shell_state_t state, state_nxt;
  logic [CW-1:0] cd_cnt, cd_nxt;
  logic [9:0] x_nxt, y_nxt;
  logic [2:0] dir_nxt;
  logic [7:0] shots_nxt;
  logic tick, hit, fire_ok, off_screen;

  frame_tick_gen u_tick (
    .clk   (clk),
    .rst   (rst),
    .vblnk (vblnk),
    .tick  (tick)
  );

  assign hit     = hit_tank | hit_obstacle;
  assign fire_ok = fire & dir_valid(fire_dir);
  assign ready   = (state == ST_IDLE);

  // next move would leave the visible area
  always_comb begin
    off_screen = 1'b0;
    unique case (1'b1)
      (direction == DIR_UP):
        off_screen = {1'b0, ypos_bullet} < SPD11;
      (direction == DIR_LEFT):
        off_screen = {1'b0, xpos_bullet} < SPD11;
      (direction == DIR_DOWN):
        off_screen = ({1'b0, ypos_bullet} + SPD11) > YLIM;
      (direction == DIR_RIGHT):
        off_screen = ({1'b0, xpos_bullet} + SPD11) > XLIM;
      default: off_screen = 1'b0;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:
        if (fire_ok) state_nxt = ST_FLIGHT;
      ST_FLIGHT:
        if (hit || (tick && off_screen))
          state_nxt = ST_COOLDOWN;
      ST_COOLDOWN:
        if (cd_cnt == '0) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // next values of shell position, direction, counters
  always_comb begin
    x_nxt     = xpos_bullet;
    y_nxt     = ypos_bullet;
    dir_nxt   = direction;
    cd_nxt    = cd_cnt;
    shots_nxt = shots_fired;
    unique case (state)
      ST_IDLE: begin
        if (fire_ok) begin
          x_nxt   = tank_x;
          y_nxt   = tank_y;
          dir_nxt = fire_dir;
          if (shots_fired != 8'hFF)
            shots_nxt = shots_fired + 8'd1;
        end
      end
      ST_FLIGHT: begin
        if (hit || (tick && off_screen)) begin
          dir_nxt = DIR_NONE;
          cd_nxt  = CD_LOAD;
        end else if (tick) begin
          unique case (1'b1)
            (direction == DIR_UP):
              y_nxt = ypos_bullet - SPD10;
            (direction == DIR_DOWN):
              y_nxt = ypos_bullet + SPD10;
            (direction == DIR_RIGHT):
              x_nxt = xpos_bullet + SPD10;
            (direction == DIR_LEFT):
              x_nxt = xpos_bullet - SPD10;
            default: ;
          endcase
        end
      end
      ST_COOLDOWN: begin
        if (cd_cnt != '0 && tick)
          cd_nxt = cd_cnt - 1'b1;
      end
      default: ;
    endcase
  end

  // registered outputs and cooldown counter
  always_ff @(posedge clk) begin
    if (rst) begin
      xpos_bullet <= '0;
      ypos_bullet <= '0;
      direction   <= DIR_NONE;
      shots_fired <= '0;
      cd_cnt      <= '0;
    end else begin
      xpos_bullet <= x_nxt;
      ypos_bullet <= y_nxt;
      direction   <= dir_nxt;
      shots_fired <= shots_nxt;
      cd_cnt      <= cd_nxt;
    end
  end

endmodule

// File: tb/tb_enemy_shell_ctl.sv
// Directed bench for enemy_shell_ctl:
// launch, moves, exits, hits, cooldown, reset.
module tb_enemy_shell_ctl;

  logic       clk = 1'b0;
  logic       rst, vblnk, fire;
  logic [2:0] fire_dir;
  logic [9:0] tank_x, tank_y;
  logic       hit_tank, hit_obstacle;
  logic [9:0] xpos_bullet, ypos_bullet;
  logic [2:0] direction;
  logic       ready;
  logic [7:0] shots_fired;

  int n_run = 0;
  int n_fail = 0;

  enemy_shell_ctl dut (
    .clk          (clk),
    .rst          (rst),
    .vblnk        (vblnk),
    .fire         (fire),
    .fire_dir     (fire_dir),
    .tank_x       (tank_x),
    .tank_y       (tank_y),
    .hit_tank     (hit_tank),
    .hit_obstacle (hit_obstacle),
    .xpos_bullet  (xpos_bullet),
    .ypos_bullet  (ypos_bullet),
    .direction    (direction),
    .ready        (ready),
    .shots_fired  (shots_fired)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // one vblnk rising edge, then one idle cycle
  task automatic frame();
    vblnk = 1'b1;
    cyc();
    vblnk = 1'b0;
    cyc();
  endtask

  task automatic shoot(
    input logic [2:0] d,
    input logic [9:0] x,
    input logic [9:0] y
  );
    fire = 1'b1;
    fire_dir = d;
    tank_x = x;
    tank_y = y;
    cyc();
    fire = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (!ready && k < 40) begin
      frame();
      k++;
    end
    check(tag, ready, 1);
  endtask

  initial begin
    rst = 1'b1;
    vblnk = 1'b0;
    fire = 1'b0;
    fire_dir = 3'd0;
    tank_x = '0;
    tank_y = '0;
    hit_tank = 1'b0;
    hit_obstacle = 1'b0;
    cyc();
    cyc();
    check("rst_ready", ready, 1);
    check("rst_x", xpos_bullet, 0);
    check("rst_y", ypos_bullet, 0);
    check("rst_dir", direction, 0);
    check("rst_shots", shots_fired, 0);
    rst = 1'b0;
    repeat (3) frame();
    check("idle_dir", direction, 0);
    check("idle_ready", ready, 1);
    check("idle_shots", shots_fired, 0);

    // up shot, three frames
    shoot(3'd1, 10'd400, 10'd300);
    check("up_dir", direction, 1);
    check("up_x0", xpos_bullet, 400);
    check("up_y0", ypos_bullet, 300);
    check("up_ready", ready, 0);
    check("up_shots", shots_fired, 1);
    repeat (3) frame();
    check("up_y3", ypos_bullet, 288);
    check("up_x3", xpos_bullet, 400);
    hit_tank = 1'b1;
    cyc();
    hit_tank = 1'b0;
    check("up_hit_dir", direction, 0);
    check("up_hit_y", ypos_bullet, 288);
    drain("up_drain");

    // left exit and exact cooldown length
    shoot(3'd4, 10'd6, 10'd50);
    check("lf_dir", direction, 4);
    frame();
    check("lf_x1", xpos_bullet, 2);
    frame();
    check("lf_exit_dir", direction, 0);
    check("lf_exit_x", xpos_bullet, 2);
    check("lf_exit_rdy", ready, 0);
    repeat (29) frame();
    check("cd_29", ready, 0);
    vblnk = 1'b1;
    cyc();
    check("cd_30", ready, 0);
    vblnk = 1'b0;
    cyc();
    check("cd_30p1", ready, 1);

    // obstacle hit on a tick cycle
    shoot(3'd3, 10'd100, 10'd80);
    check("ob_dir", direction, 3);
    vblnk = 1'b1;
    hit_obstacle = 1'b1;
    cyc();
    vblnk = 1'b0;
    hit_obstacle = 1'b0;
    check("ob_dir0", direction, 0);
    check("ob_x", xpos_bullet, 100);
    check("ob_ready", ready, 0);
    cyc();
    drain("ob_drain");

    // tank hit on a tick cycle
    shoot(3'd3, 10'd100, 10'd80);
    vblnk = 1'b1;
    hit_tank = 1'b1;
    cyc();
    vblnk = 1'b0;
    hit_tank = 1'b0;
    check("th_dir0", direction, 0);
    check("th_x", xpos_bullet, 100);
    check("th_ready", ready, 0);
    cyc();
    drain("th_drain");

    // fire ignored during flight
    shoot(3'd3, 10'd100, 10'd80);
    check("fl_shots", shots_fired, 5);
    fire = 1'b1;
    fire_dir = 3'd2;
    tank_x = 10'd10;
    tank_y = 10'd10;
    cyc();
    cyc();
    fire = 1'b0;
    check("fl_dir", direction, 3);
    check("fl_x", xpos_bullet, 100);
    check("fl_y", ypos_bullet, 80);
    check("fl_shots2", shots_fired, 5);
    hit_obstacle = 1'b1;
    cyc();
    hit_obstacle = 1'b0;
    drain("fl_drain");

    // invalid directions ignored in idle
    shoot(3'd5, 10'd50, 10'd50);
    check("bad5_ready", ready, 1);
    check("bad5_dir", direction, 0);
    shoot(3'd0, 10'd50, 10'd50);
    check("bad0_ready", ready, 1);
    check("bad_shots", shots_fired, 5);

    // reset mid-flight
    shoot(3'd2, 10'd200, 10'd150);
    frame();
    check("dn_y", ypos_bullet, 154);
    rst = 1'b1;
    cyc();
    check("mr_dir", direction, 0);
    check("mr_x", xpos_bullet, 0);
    check("mr_y", ypos_bullet, 0);
    check("mr_shots", shots_fired, 0);
    check("mr_ready", ready, 1);
    rst = 1'b0;
    shoot(3'd1, 10'd5, 10'd5);
    check("pr_dir", direction, 1);
    check("pr_shots", shots_fired, 1);
    frame();
    check("pr_y1", ypos_bullet, 1);
    frame();
    check("pr_exit", direction, 0);
    check("pr_exit_y", ypos_bullet, 1);
    drain("pr_drain");

    // right edge: 795 -> 799, then exit
    shoot(3'd3, 10'd795, 10'd20);
    frame();
    check("rt_x1", xpos_bullet, 799);
    check("rt_dir1", direction, 3);
    frame();
    check("rt_exit", direction, 0);
    check("rt_exit_x", xpos_bullet, 799);
    drain("rt_drain");

    // bottom edge: 595 -> 599, then exit
    shoot(3'd2, 10'd30, 10'd595);
    frame();
    check("bt_y1", ypos_bullet, 599);
    frame();
    check("bt_exit", direction, 0);
    check("bt_shots", shots_fired, 3);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
